// File: rtl/sodor_mem_pkg.sv
// Shared encodings and helpers for the Sodor data/instruction memory responders.
// Holds memory-type and function codes plus the access legality rule.
package sodor_mem_pkg;

  localparam logic [2:0] MT_X  = 3'd0;
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  localparam logic M_XRD = 1'b0;
  localparam logic M_XWR = 1'b1;

  // One slot of the response latency pipeline.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_stage_t;

  // Alignment and type rules; unsigned types only make sense for loads.
  function automatic logic mt_legal(input logic [2:0] typ, input logic fcn,
                                    input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (typ)
      MT_B:    ok = 1'b1;
      MT_BU:   ok = (fcn == M_XRD);
      MT_H:    ok = ~addr_lo[0];
      MT_HU:   ok = ~addr_lo[0] && (fcn == M_XRD);
      MT_W:    ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sodor_scratchpad_responder_if.sv
// Data-memory request/response bus between the core (master) and a responder (slave).
interface sodor_scratchpad_responder_if #(
  parameter int ADDR_W = 32
);

  // A request transfers on a rising edge where req_valid && req_ready. Responses
  // have no ready: resp_valid is a one-cycle pulse the master must take.
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic              req_fcn;
  logic [2:0]        req_typ;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, req_data, req_fcn, req_typ,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_fcn, req_typ,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/sodor_mem_lane_align.sv
// Byte-lane steering: store byte enables and data replication, load extract
// and sign/zero extension. Purely combinational.
module sodor_mem_lane_align
  import sodor_mem_pkg::*;
(
  input  logic [2:0]  st_typ,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_typ,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [3:0]  byte_en,
  output logic [31:0] st_word,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    byte_en = 4'b0000;
    st_word = st_data;
    case (st_typ)
      MT_B, MT_BU: begin
        byte_en = 4'b0001 << st_addr_lo;
        st_word = {4{st_data[7:0]}};
      end
      MT_H, MT_HU: begin
        byte_en = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_word = {2{st_data[15:0]}};
      end
      MT_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  always_comb begin
    shifted = ld_word >> {ld_addr_lo, 3'b000};
    ld_data = '0;
    case (ld_typ)
      MT_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      MT_BU:   ld_data = {24'h0, shifted[7:0]};
      MT_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      MT_HU:   ld_data = {16'h0, shifted[15:0]};
      MT_W:    ld_data = ld_word;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/sodor_scratchpad_responder.sv
// Single-port scratchpad answering the core's data-memory port with a fixed
// LAT-cycle response latency; illegal accesses are accepted and answered with err.
module sodor_scratchpad_responder
  import sodor_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LAT         = 1,
  parameter int ADDR_W      = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  sodor_scratchpad_responder_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic             ready_q;
  logic             accept;
  logic             legal;
  logic             wr_en;
  logic             rd_en;
  logic [IDX_W-1:0] idx;
  logic [1:0]       addr_lo;
  logic             unused_addr_hi;

  logic [3:0]       byte_en;
  logic [31:0]      st_word;
  logic [31:0]      ld_data;

  logic [31:0]      mem [DEPTH_WORDS];

  // Accept-edge capture: the synchronous read word plus what is needed to align it.
  logic             acc_valid;
  logic             acc_err;
  logic             acc_load;
  logic [2:0]       acc_typ;
  logic [1:0]       acc_lo;
  logic [31:0]      acc_rdata;

  resp_stage_t      stage_in;
  resp_stage_t      pipe [LAT];

  assign idx            = bus.req_addr[IDX_W+1:2];
  assign addr_lo        = bus.req_addr[1:0];
  assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:IDX_W+2];

  assign accept = bus.req_valid && ready_q;
  assign legal  = mt_legal(bus.req_typ, bus.req_fcn, addr_lo);
  assign wr_en  = accept && legal && (bus.req_fcn == M_XWR);
  assign rd_en  = accept && legal && (bus.req_fcn == M_XRD);

  sodor_mem_lane_align u_align (
    .st_typ     (bus.req_typ),
    .st_addr_lo (addr_lo),
    .st_data    (bus.req_data),
    .ld_typ     (acc_typ),
    .ld_addr_lo (acc_lo),
    .ld_word    (acc_rdata),
    .byte_en    (byte_en),
    .st_word    (st_word),
    .ld_data    (ld_data)
  );

  // Storage and read port carry no reset: memory contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= st_word[8*b +: 8];
      end
    end
    if (rd_en) acc_rdata <= mem[idx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q   <= 1'b0;
      acc_valid <= 1'b0;
      acc_err   <= 1'b0;
      acc_load  <= 1'b0;
      acc_typ   <= MT_X;
      acc_lo    <= 2'b00;
    end else begin
      ready_q   <= 1'b1;
      acc_valid <= accept;
      acc_err   <= accept && !legal;
      acc_load  <= rd_en;
      acc_typ   <= bus.req_typ;
      acc_lo    <= addr_lo;
    end
  end

  always_comb begin
    stage_in       = '0;
    stage_in.valid = acc_valid;
    stage_in.err   = acc_valid && acc_err;
    stage_in.data  = (acc_valid && acc_load) ? ld_data : 32'h0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= stage_in;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = pipe[LAT-1].valid;
  assign bus.resp_err   = pipe[LAT-1].valid && pipe[LAT-1].err;
  assign bus.resp_data  = pipe[LAT-1].valid ? pipe[LAT-1].data : 32'h0;

endmodule

// File: tb/tb_sodor_scratchpad_responder.sv
// Directed bench for the scratchpad responder: one LAT=1 and one LAT=3 instance,
// expected responses queued at issue time and checked by per-instance monitors.
module tb_sodor_scratchpad_responder;
  import sodor_mem_pkg::*;

  logic clock;
  logic rst1;
  logic rst3;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [32:0] exp_q1[$];
  int          due_q1[$];
  logic [32:0] exp_q3[$];
  int          due_q3[$];

  sodor_scratchpad_responder_if #(.ADDR_W(32)) bus1 ();
  sodor_scratchpad_responder_if #(.ADDR_W(32)) bus3 ();

  sodor_scratchpad_responder #(.DEPTH_WORDS(1024), .LAT(1), .ADDR_W(32)) dut1 (
    .clock (clock),
    .reset (rst1),
    .bus   (bus1)
  );

  sodor_scratchpad_responder #(.DEPTH_WORDS(1024), .LAT(3), .ADDR_W(32)) dut3 (
    .clock (clock),
    .reset (rst3),
    .bus   (bus3)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [32:0] got, input logic [32:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // drivers: called just after a negedge, return just after the next negedge
  task automatic req1(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                      input logic [31:0] data, input logic exp_err, input logic [31:0] exp_data);
    chk("ready1_at_issue", {32'h0, bus1.req_ready}, 33'h1);
    bus1.req_valid = 1'b1;
    bus1.req_fcn   = fcn;
    bus1.req_typ   = typ;
    bus1.req_addr  = addr;
    bus1.req_data  = data;
    exp_q1.push_back({exp_err, exp_data});
    due_q1.push_back(cyc + 1 + 1);
    @(negedge clock);
    bus1.req_valid = 1'b0;
  endtask

  task automatic req3(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                      input logic [31:0] data, input logic exp_err, input logic [31:0] exp_data);
    chk("ready3_at_issue", {32'h0, bus3.req_ready}, 33'h1);
    bus3.req_valid = 1'b1;
    bus3.req_fcn   = fcn;
    bus3.req_typ   = typ;
    bus3.req_addr  = addr;
    bus3.req_data  = data;
    exp_q3.push_back({exp_err, exp_data});
    due_q3.push_back(cyc + 1 + 3);
    @(negedge clock);
    bus3.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // scoreboard monitors
  always @(negedge clock) begin
    logic [32:0] e;
    int          d;
    if (bus1.resp_valid === 1'b1) begin
      n_cmp++;
      if (exp_q1.size() == 0) begin
        n_bad++;
        $display("FAIL resp1_unexpected got err=%b data=%h expected no response (cyc %0d)",
                 bus1.resp_err, bus1.resp_data, cyc);
      end else begin
        e = exp_q1.pop_front();
        d = due_q1.pop_front();
        if ({bus1.resp_err, bus1.resp_data} !== e || cyc != d) begin
          n_bad++;
          $display("FAIL resp1 got err/data=%h at cyc %0d expected %h at cyc %0d",
                   {bus1.resp_err, bus1.resp_data}, cyc, e, d);
        end
      end
    end else if (bus1.resp_valid !== 1'b0 || bus1.resp_err !== 1'b0 || bus1.resp_data !== 32'h0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL resp1_idle got valid=%b err=%b data=%h expected 0/0/0 (cyc %0d)",
               bus1.resp_valid, bus1.resp_err, bus1.resp_data, cyc);
    end
  end

  always @(negedge clock) begin
    logic [32:0] e;
    int          d;
    if (bus3.resp_valid === 1'b1) begin
      n_cmp++;
      if (exp_q3.size() == 0) begin
        n_bad++;
        $display("FAIL resp3_unexpected got err=%b data=%h expected no response (cyc %0d)",
                 bus3.resp_err, bus3.resp_data, cyc);
      end else begin
        e = exp_q3.pop_front();
        d = due_q3.pop_front();
        if ({bus3.resp_err, bus3.resp_data} !== e || cyc != d) begin
          n_bad++;
          $display("FAIL resp3 got err/data=%h at cyc %0d expected %h at cyc %0d",
                   {bus3.resp_err, bus3.resp_data}, cyc, e, d);
        end
      end
    end else if (bus3.resp_valid !== 1'b0 || bus3.resp_err !== 1'b0 || bus3.resp_data !== 32'h0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL resp3_idle got valid=%b err=%b data=%h expected 0/0/0 (cyc %0d)",
               bus3.resp_valid, bus3.resp_err, bus3.resp_data, cyc);
    end
  end

  initial begin
    bus1.req_valid = 1'b0; bus1.req_fcn = M_XRD; bus1.req_typ = MT_W;
    bus1.req_addr  = '0;   bus1.req_data = '0;
    bus3.req_valid = 1'b0; bus3.req_fcn = M_XRD; bus3.req_typ = MT_W;
    bus3.req_addr  = '0;   bus3.req_data = '0;
    rst1 = 1'b1;
    rst3 = 1'b1;

    // reset and ready release
    idle(2);
    chk("ready1_in_reset", {32'h0, bus1.req_ready}, 33'h0);
    chk("ready3_in_reset", {32'h0, bus3.req_ready}, 33'h0);
    rst1 = 1'b0;
    rst3 = 1'b0;
    #1;
    chk("ready1_at_release", {32'h0, bus1.req_ready}, 33'h0);
    @(negedge clock);
    chk("ready1_after_edge", {32'h0, bus1.req_ready}, 33'h1);
    chk("ready3_after_edge", {32'h0, bus3.req_ready}, 33'h1);
    idle(2);

    // store word then read it back on the next edge
    req1(M_XWR, MT_W, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    req1(M_XRD, MT_W, 32'h10, 32'h0,       1'b0, 32'hDEADBEEF);

    // byte store and extension
    req1(M_XWR, MT_B,  32'h13, 32'h00000080, 1'b0, 32'h0);
    req1(M_XRD, MT_B,  32'h13, 32'h0, 1'b0, 32'hFFFFFF80);
    req1(M_XRD, MT_BU, 32'h13, 32'h0, 1'b0, 32'h00000080);
    req1(M_XRD, MT_W,  32'h10, 32'h0, 1'b0, 32'h80ADBEEF);
    req1(M_XRD, MT_H,  32'h12, 32'h0, 1'b0, 32'hFFFF80AD);
    req1(M_XRD, MT_HU, 32'h10, 32'h0, 1'b0, 32'h0000BEEF);
    req1(M_XRD, MT_B,  32'h10, 32'h0, 1'b0, 32'hFFFFFFEF);
    req1(M_XWR, MT_H,  32'h12, 32'hFFFF1234, 1'b0, 32'h0);
    req1(M_XRD, MT_W,  32'h10, 32'h0, 1'b0, 32'h1234BEEF);

    // illegal accesses write nothing
    req1(M_XWR, MT_W,  32'h20, 32'h11223344, 1'b0, 32'h0);
    req1(M_XRD, MT_H,  32'h11, 32'h0, 1'b1, 32'h0);
    req1(M_XWR, MT_W,  32'h22, 32'hCAFEF00D, 1'b1, 32'h0);
    req1(M_XWR, MT_BU, 32'h20, 32'h000000AA, 1'b1, 32'h0);
    req1(M_XWR, MT_HU, 32'h20, 32'h0000BBBB, 1'b1, 32'h0);
    req1(M_XWR, MT_H,  32'h21, 32'h0000CCCC, 1'b1, 32'h0);
    req1(M_XRD, 3'd4,  32'h20, 32'h0, 1'b1, 32'h0);
    req1(M_XWR, MT_X,  32'h20, 32'hDDDDDDDD, 1'b1, 32'h0);
    req1(M_XRD, MT_W,  32'h20, 32'h0, 1'b0, 32'h11223344);

    // lane replication on byte store, half extracts
    req1(M_XWR, MT_B,  32'h21, 32'h000001FF, 1'b0, 32'h0);
    req1(M_XRD, MT_B,  32'h21, 32'h0, 1'b0, 32'hFFFFFFFF);
    req1(M_XRD, MT_HU, 32'h20, 32'h0, 1'b0, 32'h0000FF44);
    req1(M_XRD, MT_H,  32'h22, 32'h0, 1'b0, 32'h00001122);

    // address wrap modulo 4*DEPTH_WORDS
    req1(M_XWR, MT_W,  32'h00001024, 32'h55AA55AA, 1'b0, 32'h0);
    req1(M_XRD, MT_W,  32'h00000024, 32'h0, 1'b0, 32'h55AA55AA);
    req1(M_XRD, MT_W,  32'h80000024, 32'h0, 1'b0, 32'h55AA55AA);
    idle(3);

    // LAT=3: back-to-back stores then loads
    req3(M_XWR, MT_W, 32'h0, 32'hA0000000, 1'b0, 32'h0);
    req3(M_XWR, MT_W, 32'h4, 32'h00000001, 1'b0, 32'h0);
    req3(M_XWR, MT_W, 32'h8, 32'h7FFF8000, 1'b0, 32'h0);
    req3(M_XWR, MT_W, 32'hC, 32'h12345678, 1'b0, 32'h0);
    req3(M_XRD, MT_W, 32'h0, 32'h0, 1'b0, 32'hA0000000);
    req3(M_XRD, MT_W, 32'h4, 32'h0, 1'b0, 32'h00000001);
    req3(M_XRD, MT_W, 32'h8, 32'h0, 1'b0, 32'h7FFF8000);
    req3(M_XRD, MT_W, 32'hC, 32'h0, 1'b0, 32'h12345678);
    req3(M_XRD, MT_H,  32'h8, 32'h0, 1'b0, 32'hFFFF8000);
    req3(M_XRD, MT_HU, 32'hA, 32'h0, 1'b0, 32'h00007FFF);
    req3(M_XRD, MT_B,  32'hC, 32'h0, 1'b0, 32'h00000078);
    req3(M_XRD, MT_B,  32'hF, 32'h0, 1'b0, 32'h00000012);
    req3(M_XRD, MT_BU, 32'h3, 32'h0, 1'b0, 32'h000000A0);
    req3(M_XRD, MT_W,  32'h6, 32'h0, 1'b1, 32'h0);
    idle(5);

    // reset with two loads in flight
    req3(M_XWR, MT_W, 32'h30, 32'h0BADF00D, 1'b0, 32'h0);
    idle(5);
    req3(M_XRD, MT_W, 32'h0, 32'h0, 1'b0, 32'hA0000000);
    req3(M_XRD, MT_W, 32'h4, 32'h0, 1'b0, 32'h00000001);
    exp_q3.delete();
    due_q3.delete();
    rst3 = 1'b1;
    @(negedge clock);
    chk("ready3_mid_reset", {32'h0, bus3.req_ready}, 33'h0);
    @(negedge clock);
    rst3 = 1'b0;
    @(negedge clock);
    chk("ready3_after_reset", {32'h0, bus3.req_ready}, 33'h1);
    idle(6);
    req3(M_XRD, MT_W, 32'h30, 32'h0, 1'b0, 32'h0BADF00D);
    idle(6);

    chk("exp_q1_drained", {1'b0, 32'(exp_q1.size())}, 33'h0);
    chk("exp_q3_drained", {1'b0, 32'(exp_q3.size())}, 33'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sodor_scratchpad_responder.md
Name: sodor_scratchpad_responder

Overview:
- Single-port scratchpad memory that acts as the responder end of the core's data-memory request/response interface.
- Accepts one load or store request per cycle and returns a response exactly LAT cycles later.
- Handles byte/half/word lane steering, load sign- or zero-extension, and misalignment errors.
- Sits beside the 2-stage core in the rv32 test harness, in place of the behavioural memory model.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two.
- LAT, 1: response latency in cycles, legal range 1..4.
- ADDR_W, 32: request address width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  ADDR_W  byte address.
- req_data  in  32  store data, right-aligned.
- req_fcn  in  1  0 = load (M_XRD), 1 = store (M_XWR).
- req_typ  in  3  MT_B=1, MT_H=2, MT_W=3, MT_BU=5, MT_HU=6.
- resp_valid  out  1  response valid; the receiver cannot stall it.
- resp_data  out  32  load result after extension; 0 for stores and errors.
- resp_err  out  1  misaligned access or illegal typ.

Behaviour:
- Reset (async assert):
  - All pipeline valid bits are cleared, so resp_valid=0, resp_data=0, resp_err=0.
  - req_ready=0.
  - Memory contents are not reset.
- req_ready:
  - It is a register that becomes 1 on the first rising edge after reset deasserts.
  - It then stays 1; there is no backpressure.
- Accept: a request fires when req_valid && req_ready at a rising edge.
- Word index: req_addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Legality:
  - typ must be in {1,2,3,5,6}.
  - H/HU need addr[0]=0.
  - W needs addr[1:0]=0.
  - A store with typ BU or HU is illegal.
  - An illegal request is still accepted. It writes nothing and produces resp_err=1 with resp_data=0 after LAT cycles.
- Store:
  - The byte-enable mask is generated from typ and addr[1:0].
  - Data is replicated into lanes: a byte goes to all 4 lanes, a half to both halves.
  - The write commits at the accept edge.
- Load:
  - The word is read at the accept edge, so it reflects every store accepted on earlier edges.
  - A store and a load are never accepted on the same edge (single port).
  - The selected byte/half is shifted to bit 0. B/H are sign-extended, BU/HU zero-extended.
- Response timing:
  - A request accepted at edge N produces resp_valid=1 for exactly one cycle after edge N+LAT.
  - resp_data and resp_err are valid only while resp_valid=1, and are 0 otherwise.
  - The pipeline is LAT stages of {valid, err, data}. Back-to-back accepts yield back-to-back responses in order.
- Reset mid-operation: all in-flight responses are dropped and none are issued after reset. Stores already committed remain in memory.
- Write followed by read of the same word on the next edge: the read returns the new data.

Decomposition:
- Shared package sodor_mem_pkg holds:
  - MT_B, MT_H, MT_W, MT_BU, MT_HU, MT_X
  - M_XRD, M_XWR
  - a function mt_legal(typ, fcn, addr_lo)
- One sub-module, sodor_mem_lane_align: a combinational unit that produces the byte-enable mask, the store-data replication, and the load extract/extension. It is shared with the future instruction-port responder.
- Storage is a reg array written per byte lane.
- The top module holds the ready register, the legality check and the latency pipeline.

Test Plan:
1. Reset, then 2 idle cycles:
   - req_ready=0 during reset, and 1 one edge after deassert.
   - resp_valid stays 0 throughout.
2. LAT=1: store W 0xDEADBEEF at 0x10, then load W at 0x10 on the next cycle:
   - store response: resp_valid=1, resp_data=0, resp_err=0;
   - next cycle: resp_data=0xDEADBEEF.
3. Store B 0x80 at 0x13, then loads from 0x13:
   - load B returns 0xFFFFFF80;
   - load BU returns 0x00000080;
   - load W at 0x10 returns 0x80ADBEEF.
4. Load H at 0x11, then store W at 0x22:
   - both responses have resp_err=1 and resp_data=0;
   - a later load W at 0x20 shows memory unchanged.
5. LAT=3: 4 back-to-back loads at 0x0, 0x4, 0x8, 0xC:
   - 4 consecutive resp_valid cycles, starting 3 edges after the first accept, in order.
6. Reset asserted with 2 responses in flight:
   - no responses appear after release;
   - a store committed before reset is still readable.
